// File: rtl/sb_rx_deser_pkg.sv
// rtl/sb_rx_deser_pkg.sv - shared sideband RX definitions
//
// Purpose: state encoding and default geometry shared by the sideband
//          deserializer and the downstream RX FSM.
// Ports:   none (package).

package sb_rx_deser_pkg;

   // Default packet width in UI and minimum idle UI between packets.
   localparam int SB_DATA_W  = 64;
   localparam int SB_GAP_MIN = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } sb_state_t;

   // Counter width for a count range of 0..n-1, never narrower than one bit.
   function automatic int sb_cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sb_rx_deser.sv
// rtl/sb_rx_deser.sv - sideband serial-to-parallel packet deserializer
//
// Purpose: collects DATA_W serial bits (LSB first) into a packet, enforces a
//          minimum idle gap between packets and flags truncated packets.
// Ports:
//   i_clk          sideband RX clock, rising-edge sampling
//   i_rst_n        asynchronous active-low reset
//   i_enable       deserializer enable, low forces IDLE
//   i_bit_valid    serial bit present this cycle
//   i_serial_data  serial bit
//   o_deser_data   last completed packet, bit 0 = first bit received
//   o_de_ser_done  one-cycle pulse, o_deser_data newly valid
//   o_frame_error  one-cycle pulse, truncated packet or short gap
//   o_busy         high while a packet is being shifted in

module sb_rx_deser
   import sb_rx_deser_pkg::*;
#(
   parameter int DATA_W  = SB_DATA_W,
   parameter int GAP_MIN = SB_GAP_MIN
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_enable,
   input  logic              i_bit_valid,
   input  logic              i_serial_data,
   output logic [DATA_W-1:0] o_deser_data,
   output logic              o_de_ser_done,
   output logic              o_frame_error,
   output logic              o_busy
);

   localparam int CNT_W = sb_cnt_w(DATA_W);
   localparam int GAP_W = sb_cnt_w(GAP_MIN + 1);

   localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(DATA_W - 1);
   localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(GAP_MIN);

   sb_state_t         state;
   sb_state_t         state_nxt;
   logic [CNT_W-1:0]  bit_cnt;
   logic [CNT_W-1:0]  bit_cnt_nxt;
   logic [GAP_W-1:0]  gap_cnt;
   logic [GAP_W-1:0]  gap_cnt_nxt;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] shreg_nxt;
   logic [DATA_W-1:0] data_nxt;
   logic              done_nxt;
   logic              err_nxt;
   logic              last_bit;

   assign last_bit = (bit_cnt == LAST_IDX);

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; enable low overrides everything, including a last bit.
   always_comb begin
      state_nxt = state;
      if (!i_enable) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_bit_valid) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
               if (!i_bit_valid)  state_nxt = ST_IDLE;
               else if (last_bit) state_nxt = ST_GAP;
            end
            ST_GAP: begin
               if (i_bit_valid) state_nxt = ST_SHIFT;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // Output / datapath next values; registered below so no input reaches an
   // output combinationally.
   always_comb begin
      bit_cnt_nxt = bit_cnt;
      gap_cnt_nxt = gap_cnt;
      shreg_nxt   = shreg;
      data_nxt    = o_deser_data;
      done_nxt    = 1'b0;
      err_nxt     = 1'b0;
      if (!i_enable) begin
         bit_cnt_nxt = '0;
         gap_cnt_nxt = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_bit_valid) begin
                  shreg_nxt[0] = i_serial_data;
                  bit_cnt_nxt  = CNT_W'(1);
               end
            end
            ST_SHIFT: begin
               if (!i_bit_valid) begin
                  bit_cnt_nxt = '0;
                  err_nxt     = 1'b1;
               end else begin
                  shreg_nxt[bit_cnt] = i_serial_data;
                  // Explicit zero keeps the wrap correct for non power-of-two widths.
                  bit_cnt_nxt = last_bit ? '0 : bit_cnt + CNT_W'(1);
                  if (last_bit) begin
                     data_nxt    = shreg_nxt;
                     done_nxt    = 1'b1;
                     gap_cnt_nxt = '0;
                  end
               end
            end
            ST_GAP: begin
               if (i_bit_valid) begin
                  // A short gap is flagged but the bit still starts a packet,
                  // so the receiver resynchronises on the early sender.
                  shreg_nxt[0] = i_serial_data;
                  bit_cnt_nxt  = CNT_W'(1);
                  gap_cnt_nxt  = '0;
                  err_nxt      = (gap_cnt < GAP_LIMIT);
               end else if (gap_cnt != GAP_LIMIT) begin
                  gap_cnt_nxt = gap_cnt + GAP_W'(1);
               end
            end
            default: begin
               bit_cnt_nxt = '0;
               gap_cnt_nxt = '0;
            end
         endcase
      end
   end

   // Datapath and output registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bit_cnt       <= '0;
         gap_cnt       <= '0;
         shreg         <= '0;
         o_deser_data  <= '0;
         o_de_ser_done <= 1'b0;
         o_frame_error <= 1'b0;
         o_busy        <= 1'b0;
      end else begin
         bit_cnt       <= bit_cnt_nxt;
         gap_cnt       <= gap_cnt_nxt;
         shreg         <= shreg_nxt;
         o_deser_data  <= data_nxt;
         o_de_ser_done <= done_nxt;
         o_frame_error <= err_nxt;
         o_busy        <= (state_nxt == ST_SHIFT);
      end
   end

endmodule

// File: tb/tb_sb_rx_deser.sv
// tb/tb_sb_rx_deser.sv - directed self-checking bench for sb_rx_deser

module tb_sb_rx_deser;
   import sb_rx_deser_pkg::*;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_enable;
   logic        i_bit_valid;
   logic        i_serial_data;
   logic [63:0] o_deser_data;
   logic        o_de_ser_done;
   logic        o_frame_error;
   logic        o_busy;

   int checks;
   int errors;
   int done_cnt;
   int err_cnt;

   sb_rx_deser #(.DATA_W(64), .GAP_MIN(32)) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_enable      (i_enable),
      .i_bit_valid   (i_bit_valid),
      .i_serial_data (i_serial_data),
      .o_deser_data  (o_deser_data),
      .o_de_ser_done (o_de_ser_done),
      .o_frame_error (o_frame_error),
      .o_busy        (o_busy)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Pulse counters, sampled mid-cycle so each one-cycle pulse counts once.
   always @(negedge i_clk) begin
      if (o_de_ser_done === 1'b1) done_cnt++;
      if (o_frame_error === 1'b1) err_cnt++;
   end

   task automatic send_bit(input logic b);
      i_bit_valid   = 1'b1;
      i_serial_data = b;
      @(posedge i_clk);
      #1;
   endtask

   task automatic send_bits(input logic [63:0] p, input int n);
      for (int i = 0; i < n; i++) send_bit(p[i]);
   endtask

   task automatic idle(input int n);
      i_bit_valid   = 1'b0;
      i_serial_data = 1'b0;
      repeat (n) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   task automatic clear_counts();
      done_cnt = 0;
      err_cnt  = 0;
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0; i_enable = 1'b0; i_bit_valid = 1'b0; i_serial_data = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      checks++; if (o_deser_data !== 64'h0) begin errors++; $display("FAIL reset_data got %h exp 0", o_deser_data); end
      checks++; if (o_de_ser_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", o_de_ser_done); end
      checks++; if (o_frame_error !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", o_frame_error); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", o_busy); end
      @(negedge i_clk);
      i_rst_n  = 1'b1;
      i_enable = 1'b1;
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_single_packet();
      logic [63:0] p;
      p = 64'hAAAA_AAAA_AAAA_AAAA;
      clear_counts();
      send_bit(p[0]);
      checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL busy_shift got %b exp 1", o_busy); end
      for (int i = 1; i < 63; i++) send_bit(p[i]);
      checks++; if (o_de_ser_done !== 1'b0) begin errors++; $display("FAIL early_done got %b exp 0", o_de_ser_done); end
      send_bit(p[63]);
      checks++; if (o_de_ser_done !== 1'b1) begin errors++; $display("FAIL aaaa_done got %b exp 1", o_de_ser_done); end
      checks++; if (o_deser_data !== p) begin errors++; $display("FAIL aaaa_data got %h exp %h", o_deser_data, p); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL busy_gap got %b exp 0", o_busy); end
      idle(1);
      checks++; if (o_de_ser_done !== 1'b0) begin errors++; $display("FAIL done_width got %b exp 0", o_de_ser_done); end
      idle(40);
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL aaaa_done_count got %0d exp 1", done_cnt); end
      checks++; if (o_deser_data !== p) begin errors++; $display("FAIL aaaa_hold got %h exp %h", o_deser_data, p); end
   endtask

   task automatic test_back_to_back();
      clear_counts();
      send_bits(64'h1, 64);
      checks++; if (o_deser_data !== 64'h1) begin errors++; $display("FAIL b2b_first got %h exp 1", o_deser_data); end
      idle(32);
      send_bits(64'h8000_0000_0000_0000, 64);
      checks++; if (o_deser_data !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL b2b_second got %h exp 8000000000000000", o_deser_data); end
      idle(1);
      checks++; if (done_cnt !== 2) begin errors++; $display("FAIL b2b_done_count got %0d exp 2", done_cnt); end
      checks++; if (err_cnt !== 0) begin errors++; $display("FAIL b2b_err_count got %0d exp 0", err_cnt); end
   endtask

   task automatic test_short_gap();
      idle(40);
      clear_counts();
      send_bits(64'h0123_4567_89AB_CDEF, 64);
      idle(31);
      send_bit(1'b0);
      checks++; if (o_frame_error !== 1'b1) begin errors++; $display("FAIL gap31_err got %b exp 1", o_frame_error); end
      send_bits(64'hFEDC_BA98_7654_3210 >> 1, 63);
      checks++; if (o_de_ser_done !== 1'b1) begin errors++; $display("FAIL gap31_done got %b exp 1", o_de_ser_done); end
      checks++; if (o_deser_data !== 64'hFEDC_BA98_7654_3210) begin errors++; $display("FAIL gap31_data got %h exp fedcba9876543210", o_deser_data); end
      idle(1);
      checks++; if (err_cnt !== 1) begin errors++; $display("FAIL gap31_err_count got %0d exp 1", err_cnt); end
      checks++; if (done_cnt !== 2) begin errors++; $display("FAIL gap31_done_count got %0d exp 2", done_cnt); end
   endtask

   task automatic test_truncated();
      idle(40);
      clear_counts();
      send_bits(64'h1234_5678_9ABC_DEF0, 40);
      idle(1);
      checks++; if (o_frame_error !== 1'b1) begin errors++; $display("FAIL trunc_err got %b exp 1", o_frame_error); end
      checks++; if (o_deser_data !== 64'hFEDC_BA98_7654_3210) begin errors++; $display("FAIL trunc_hold got %h exp fedcba9876543210", o_deser_data); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL trunc_busy got %b exp 0", o_busy); end
      idle(2);
      send_bits(64'h5555_0000_FFFF_3C3C, 64);
      checks++; if (o_deser_data !== 64'h5555_0000_FFFF_3C3C) begin errors++; $display("FAIL trunc_next got %h exp 55550000ffff3c3c", o_deser_data); end
      idle(1);
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL trunc_done_count got %0d exp 1", done_cnt); end
      checks++; if (err_cnt !== 1) begin errors++; $display("FAIL trunc_err_count got %0d exp 1", err_cnt); end
   endtask

   task automatic test_reset_mid_packet();
      idle(40);
      clear_counts();
      send_bits(64'hFFFF_FFFF_FFFF_FFFF, 20);
      i_bit_valid   = 1'b1;
      i_serial_data = 1'b1;
      #2 i_rst_n = 1'b0;
      #1;
      checks++; if (o_deser_data !== 64'h0) begin errors++; $display("FAIL rst_mid_data got %h exp 0", o_deser_data); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", o_busy); end
      checks++; if (o_de_ser_done !== 1'b0 || o_frame_error !== 1'b0) begin errors++; $display("FAIL rst_mid_pulse got %b%b exp 00", o_de_ser_done, o_frame_error); end
      i_bit_valid = 1'b0;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;
      send_bits(64'h0F0F_1E1E_2D2D_3C3C, 64);
      checks++; if (o_deser_data !== 64'h0F0F_1E1E_2D2D_3C3C) begin errors++; $display("FAIL rst_mid_next got %h exp 0f0f1e1e2d2d3c3c", o_deser_data); end
      idle(1);
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL rst_mid_done_count got %0d exp 1", done_cnt); end
      checks++; if (err_cnt !== 0) begin errors++; $display("FAIL rst_mid_err_count got %0d exp 0", err_cnt); end
   endtask

   task automatic test_enable_last_bit();
      logic [63:0] f;
      f = 64'hC3C3_A5A5_0110_7EE7;
      idle(40);
      clear_counts();
      send_bits(f, 63);
      i_enable      = 1'b0;
      i_bit_valid   = 1'b1;
      i_serial_data = f[63];
      @(posedge i_clk);
      #1;
      checks++; if (o_de_ser_done !== 1'b0) begin errors++; $display("FAIL en63_done got %b exp 0", o_de_ser_done); end
      checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL en63_state got %0d exp %0d", dut.state, ST_IDLE); end
      checks++; if (o_deser_data !== 64'h0F0F_1E1E_2D2D_3C3C) begin errors++; $display("FAIL en63_hold got %h exp 0f0f1e1e2d2d3c3c", o_deser_data); end
      i_enable = 1'b1;
      idle(2);
      checks++; if (done_cnt !== 0) begin errors++; $display("FAIL en63_done_count got %0d exp 0", done_cnt); end
      checks++; if (err_cnt !== 0) begin errors++; $display("FAIL en63_err_count got %0d exp 0", err_cnt); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      clear_counts();
      test_reset();
      test_single_packet();
      test_back_to_back();
      test_short_gap();
      test_truncated();
      test_reset_mid_packet();
      test_enable_last_bit();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
